// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus responder: FSM encoding and bus geometry.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam int WORD_BYTES      = 4;
  localparam int OFFSET_W        = 2;
  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered,
// read-before-write output that can be synchronously cleared.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  rclr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage array: byte lanes written only where enabled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Output register captures the pre-write word on every enabled access.
  always_ff @(posedge clk_i) begin
    if (rclr_i) begin
      rdata_q <= 32'h0000_0000;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_bus_responder.sv
// Memory-side responder of the CPU bus: latches one request, waits WAIT_STATES
// cycles, commits to the word RAM and returns a one-cycle ready pulse.
module memory_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [WORD_BYTES-1:0] be_i,
  output logic [31:0]           rdata_o,
  output logic                  ready_o,
  output logic                  error_o,
  output logic                  busy_o
);

  localparam int          AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

  bus_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic [31:0]           addr_q, wdata_q;
  logic [WORD_BYTES-1:0] be_q;
  logic                  ready_q, error_q, busy_q;

  logic                  accept, commit;
  logic                  cur_we;
  logic [31:0]           cur_addr, cur_wdata;
  logic [WORD_BYTES-1:0] cur_be;
  logic [31-OFFSET_W:0]  word_idx;
  logic                  addr_err;
  logic                  ram_en, ram_rclr;
  logic [WORD_BYTES-1:0] ram_be;

  // With zero wait states the commit happens at the accept edge, before the
  // latches are loaded, so the live inputs are used in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = we_i;
      cur_addr  = addr_i;
      cur_wdata = wdata_i;
      cur_be    = be_i;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign word_idx = cur_addr[31:OFFSET_W];
  assign addr_err = (cur_addr[OFFSET_W-1:0] != {OFFSET_W{1'b0}}) ||
                    ({{OFFSET_W{1'b0}}, word_idx} >= DEPTH_W);

  // Next-state logic for the IDLE / WAIT / RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign ram_en   = commit & ~addr_err & ~reset_i;
  assign ram_rclr = reset_i | (commit & addr_err);
  assign ram_be   = cur_we ? cur_be : {WORD_BYTES{1'b0}};

  // State, counter, request latches and registered response flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= {WORD_BYTES{1'b0}};
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (commit) begin
        error_q <= addr_err;
      end
      ready_q <= (state_d == ST_RESP);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .be_i    (ram_be),
    .addr_i  (word_idx[AW-1:0]),
    .wdata_i (cur_wdata),
    .rclr_i  (ram_rclr),
    .rdata_o (rdata_o)
  );

  assign ready_o = ready_q;
  assign error_o = error_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance sharing clock and reset.
module tb_memory_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready, error, busy;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic [31:0] rdata0;
  logic        ready0, error0, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_bus_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .ready_o(ready),
    .error_o(error), .busy_o(busy)
  );

  memory_bus_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .be_i(be0), .rdata_o(rdata0), .ready_o(ready0),
    .error_o(error0), .busy_o(busy0)
  );

  // One transaction on the WAIT_STATES=2 instance; inputs are scrambled right
  // after the accept edge. lat counts falling edges after accept until ready.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic er,
                     output int lat, output logic busy_ok, output logic post_rdy,
                     output logic post_busy);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; wdata = ~d; be = ~b;
    lat = -1; busy_ok = 1'b1; rd = 32'h0; er = 1'b0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ready === 1'b1) begin
        lat = n; rd = rdata; er = error;
      end
    end
    @(negedge clk);
    post_rdy = ready; post_busy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({ready0, busy0, rdata0} !== 34'h0) begin errors++; $display("FAIL reset_ws0: got %h want 0", {ready0, busy0, rdata0}); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, bok, pr, pb; int lat;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, bok, pr, pb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_error: got %b want 0", er); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", bok); end
    checks++; if ({pr, pb} !== 2'b00) begin errors++; $display("FAIL wr_after: got %b want 00", {pr, pb}); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if ({er, lat} !== {1'b0, 32'd3}) begin errors++; $display("FAIL rd_resp: got er=%b lat=%0d want 0/3", er, lat); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic er, bok, pr, pb; int lat;
    txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat, bok, pr, pb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL be_old_word: got %h want deadbeef", rd); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL be_merge: got %h want deadaaef", rd); end
    txn(1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat, bok, pr, pb);
    checks++; if ({er, lat} !== {1'b0, 32'd3}) begin errors++; $display("FAIL be0_resp: got er=%b lat=%0d want 0/3", er, lat); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL be0_nochange: got %h want deadaaef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, bok, pr, pb; int lat;
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat, bok, pr, pb);
    txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if ({er, rd, lat} !== {1'b1, 32'h0, 32'd3}) begin errors++; $display("FAIL err_misaligned: got er=%b rd=%h lat=%0d want 1/0/3", er, rd, lat); end
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er, lat, bok, pr, pb);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL err_range: got er=%b rd=%h want 1/0", er, rd); end
    txn(1'b1, 32'h0000_0FFC, 32'h7777_7777, 4'hF, rd, er, lat, bok, pr, pb);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_ok: got er=%b want 0", er); end
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if ({er, rd} !== {1'b0, 32'h0BADF00D}) begin errors++; $display("FAIL no_alias: got er=%b rd=%h want 0/0badf00d", er, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, bok, pr, pb; int lat;
    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];
    int          ptime [8];
    logic [31:0] pdata [8];
    logic        perr [8];
    int          npulse;
    txn(1'b1, 32'h4, 32'h44444444, 4'hF, rd, er, lat, bok, pr, pb);
    txn(1'b1, 32'h8, 32'h88888888, 4'hF, rd, er, lat, bok, pr, pb);
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h4};
    exp_data = '{32'h0BADF00D, 32'h44444444, 32'h88888888, 32'hDEADAAEF, 32'h44444444};
    npulse = 0;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (npulse < 8) begin
          ptime[npulse] = k; pdata[npulse] = rdata; perr[npulse] = error;
        end
        npulse++;
      end
      if (k < 20) begin
        req = 1'b1; we = 1'b0; wdata = 32'h0; be = 4'h0;
        addr = (k % 4 == 0) ? exp_addr[k/4] : 32'h13;
      end else begin
        req = 1'b0;
      end
    end
    checks++; if (npulse !== 5) begin errors++; $display("FAIL b2b_pulses: got %0d want 5", npulse); end
    for (int i = 0; i < 5 && i < npulse; i++) begin
      checks++;
      if (ptime[i] !== 3 + 4*i || pdata[i] !== exp_data[i] || perr[i] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_resp%0d: got t=%0d rd=%h er=%b want t=%0d rd=%h er=0",
                 i, ptime[i], pdata[i], perr[i], 3 + 4*i, exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, bok, pr, pb; int lat; int pulses;
    txn(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat, bok, pr, pb);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_wait: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, ready} !== 2'b00) begin errors++; $display("FAIL mid_after_reset: got busy,ready=%b want 00", {busy, ready}); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_ready: got %0d want 0", pulses); end
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, bok, pr, pb);
    checks++; if ({er, rd} !== {1'b0, 32'h0}) begin errors++; $display("FAIL mid_no_commit: got er=%b rd=%h want 0/0", er, rd); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h5A5A5A5A; be0 = 4'hF;
    @(negedge clk);
    checks++; if ({ready0, busy0, error0} !== 3'b110) begin errors++; $display("FAIL ws0_wr_resp: got %b want 110", {ready0, busy0, error0}); end
    we0 = 1'b0; wdata0 = 32'h0; be0 = 4'h0;
    @(negedge clk);
    checks++; if ({ready0, busy0} !== 2'b00) begin errors++; $display("FAIL ws0_idle_gap: got %b want 00", {ready0, busy0}); end
    @(negedge clk);
    req0 = 1'b0;
    checks++; if ({ready0, error0, rdata0} !== {2'b10, 32'h5A5A5A5A}) begin errors++; $display("FAIL ws0_rd_resp: got rdy=%b er=%b rd=%h want 1/0/5a5a5a5a", ready0, error0, rdata0); end
    @(negedge clk);
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL ws0_pulse_len: got %b want 0", ready0); end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_responder.md
Name: memory_bus_responder

Overview:
- Responder (memory side) of the CPU memory bus driven by the Memory Address Register (MAR) and the data path.
- Accepts one read or write request at a time, inserts a configurable number of wait states, then returns a one-cycle ready pulse with read data or an error flag.
- Holds a word-organised RAM with byte-enabled writes, so the CPU datapath and the MAR can be tested against a realistic slave with latency.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; legal range 2..65536.
- WAIT_STATES, 2, number of cycles spent in WAIT before the response; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; latched with req.
- addr  input  32  byte address from the MAR; latched with req.
- wdata  input  32  write data; latched with req.
- be  input  4  byte enables for writes (bit i selects wdata[8i+7:8i]); ignored on reads.
- rdata  output  32  read data; valid while ready=1.
- ready  output  1  one-cycle response pulse.
- error  output  1  response error; valid while ready=1.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state goes to IDLE; ready=0, error=0, rdata=0, busy=0; the wait counter is cleared.
  - RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with req=1, latch we, addr, wdata and be.
  - If WAIT_STATES>0, go to WAIT and load the counter with WAIT_STATES-1; otherwise go directly to RESP.
- WAIT:
  - The counter decrements each cycle.
  - At the edge where the counter is 0, go to RESP, and at that same edge:
    - commit a write, or
    - register read data into rdata.
  - When WAIT_STATES=0, the commit happens at the accept edge.
- RESP:
  - Lasts exactly one cycle with ready=1, then returns to IDLE.
  - rdata and error hold their values until the next commit or a reset.
- Latency:
  - ready is high during the cycle that follows edge T0+WAIT_STATES, where T0 is the accept edge.
  - Throughput is one transaction per WAIT_STATES+2 cycles.
- req is ignored in WAIT and RESP. A req still high in the first IDLE cycle after RESP is accepted as a new transaction.
- Inputs that change after the accept edge have no effect, because they are latched at that edge.
- Word index is addr[31:2]. Error conditions:
  - addr[1:0] != 0, or
  - word index >= DEPTH.
- On error:
  - ready still pulses with error=1 and rdata=0; no RAM write occurs.
  - There is no address aliasing.
- Read response: error=0 and rdata = the full 32-bit word.
- Write response: error=0, and rdata returns the word's value before the write (as it was at the commit edge).
- A write with be=4'b0000 leaves memory unchanged; ready still pulses with error=0.
- Reset during WAIT aborts the transaction: no write is committed and no ready pulse occurs. Reset during RESP suppresses ready from the next cycle.
- busy=1 in WAIT and RESP.

Decomposition:
- Package mem_bus_pkg contains:
  - state encoding constants for IDLE, WAIT and RESP;
  - WORD_BYTES=4;
  - the width of the byte-offset field (2);
  - the maximum WAIT_STATES value (15).
- One sub-module: mem_word_array, a synchronous single-port RAM (DEPTH x 32) with a 4-bit byte-write enable and a registered read.
- The FSM, counter, address decode and error check stay in the top module.

Test Plan (DEPTH=1024, WAIT_STATES=2 unless stated):
1. Write followed by read:
   - Stimulus: write addr=0x10, wdata=0xDEADBEEF, be=4'hF accepted at edge T0.
   - Required: ready=1 only during the cycle after edge T0+2, with error=0 and busy=1 from T0 until ready falls.
   - Then read addr=0x10 -> rdata=0xDEADBEEF, error=0.
2. Byte enables:
   - Stimulus: write addr=0x10, wdata=0x0000AA00, be=4'b0010.
   - Required: a following read of 0x10 returns 0xDEADAAEF.
   - A write with be=0 leaves the word at 0xDEADAAEF.
3. Error cases:
   - Read addr=0x13 -> ready=1, error=1, rdata=0.
   - Write addr=0x1000 (index 1024) -> error=1.
   - A read of addr=0x0 afterwards is unchanged (no aliasing).
4. Continuous request:
   - Stimulus: req held high for 20 cycles; addr changed during WAIT.
   - Required: exactly 5 ready pulses, spaced 4 cycles apart; each response uses the address latched at its accept edge.
5. Reset mid-operation:
   - Stimulus: write 0x20 with 0x00000000; then start a write 0x20 with 0x12345678 and assert reset in WAIT.
   - Required: no ready pulse; busy=0 after the reset edge; a later read of 0x20 returns 0x00000000.
6. Zero wait states (WAIT_STATES=0 instance):
   - Stimulus: read accepted at edge T0.
   - Required: ready high in the cycle immediately following T0; the next request is accepted at edge T0+2.
